// File: rtl/fpu_add_sched.sv
`default_nettype none
// fpu_add_sched: round-robin issue scheduler for the shared add/round datapath,
// with credit-protected in-order result FIFO. Rev 1.0
module fpu_add_sched #(
  parameter int LAT    = 2,
  parameter int RM_DLY = 1,
  parameter int DEPTH  = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req0_valid_i,
  output logic        req0_ready_o,
  input  logic [31:0] req0_a_i,
  input  logic [31:0] req0_b_i,
  input  logic [2:0]  req0_rmode_i,
  input  logic        req1_valid_i,
  output logic        req1_ready_o,
  input  logic [31:0] req1_a_i,
  input  logic [31:0] req1_b_i,
  input  logic [2:0]  req1_rmode_i,
  output logic [31:0] dp_a_o,
  output logic [31:0] dp_b_o,
  output logic [2:0]  dp_rmode_o,
  input  logic [31:0] dp_result_i,
  output logic        res_valid_o,
  input  logic        res_ready_i,
  output logic [31:0] res_data_o,
  output logic        res_id_o
);

  localparam int OW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [OW-1:0] OCC_MAX  = OW'(DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  logic [OW-1:0] occ;
  logic [OW-1:0] cnt;
  logic          prio;
  logic          grant;
  logic          any_req;
  logic          can_issue;
  logic          issue;
  logic          pop;
  logic          wr;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [31:0]   mem_data [DEPTH];
  logic          mem_id   [DEPTH];
  logic [LAT-1:0] tok_v;
  logic [LAT-1:0] tok_id;
  logic [2:0]    rm_line  [RM_DLY+1];

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  // Priority only matters when both ports compete.
  always_comb begin
    grant = 1'b0;
    if (req0_valid_i && req1_valid_i) begin
      grant = prio;
    end else if (req1_valid_i) begin
      grant = 1'b1;
    end
  end

  assign any_req      = req0_valid_i | req1_valid_i;
  assign can_issue    = occ < OCC_MAX;
  assign issue        = can_issue & any_req;
  assign req0_ready_o = issue & ~grant;
  assign req1_ready_o = issue & grant;
  assign pop          = res_valid_o & res_ready_i;
  assign wr           = tok_v[LAT-1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      occ    <= '0;
      prio   <= 1'b0;
      dp_a_o <= '0;
      dp_b_o <= '0;
      tok_v  <= '0;
      tok_id <= '0;
      for (int i = 0; i <= RM_DLY; i++) rm_line[i] <= '0;
    end else begin
      case ({issue, pop})
        2'b10:   occ <= occ + OW'(1);
        2'b01:   occ <= occ - OW'(1);
        default: occ <= occ;
      endcase
      if (issue) begin
        prio       <= ~grant;
        dp_a_o     <= grant ? req1_a_i : req0_a_i;
        dp_b_o     <= grant ? req1_b_i : req0_b_i;
        rm_line[0] <= grant ? req1_rmode_i : req0_rmode_i;
      end
      // Free-running delay so rmode meets its operands at the rounder stage.
      for (int i = 1; i <= RM_DLY; i++) rm_line[i] <= rm_line[i-1];
      tok_v[0]  <= issue;
      tok_id[0] <= grant;
      for (int i = 1; i < LAT; i++) begin
        tok_v[i]  <= tok_v[i-1];
        tok_id[i] <= tok_id[i-1];
      end
    end
  end

  assign dp_rmode_o = rm_line[RM_DLY];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_id[i]   <= 1'b0;
      end
    end else begin
      if (wr) begin
        mem_data[wr_ptr] <= dp_result_i;
        mem_id[wr_ptr]   <= tok_id[LAT-1];
        wr_ptr           <= ptr_next(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      case ({wr, pop})
        2'b10:   cnt <= cnt + OW'(1);
        2'b01:   cnt <= cnt - OW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign res_valid_o = (cnt != '0);
  assign res_data_o  = mem_data[rd_ptr];
  assign res_id_o    = mem_id[rd_ptr];

endmodule
`default_nettype wire

// File: tb/tb_fpu_add_sched.sv
`default_nettype none
// tb_fpu_add_sched: directed bench with a behavioural two-stage add/round
// datapath and an issue-order scoreboard.
module tb_fpu_add_sched;

  localparam int LAT    = 2;
  localparam int RM_DLY = 1;
  localparam int DEPTH  = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_rm, req1_rm;
  logic [31:0] dp_a, dp_b, dp_result;
  logic [2:0]  dp_rmode;
  logic        res_valid, res_ready, res_id;
  logic [31:0] res_data;

  int checks = 0;
  int errors = 0;
  logic [32:0] sb[$];
  logic [32:0] got[$];

  always #5 clk = ~clk;

  fpu_add_sched #(.LAT(LAT), .RM_DLY(RM_DLY), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req0_valid_i(req0_valid), .req0_ready_o(req0_ready),
    .req0_a_i(req0_a), .req0_b_i(req0_b), .req0_rmode_i(req0_rm),
    .req1_valid_i(req1_valid), .req1_ready_o(req1_ready),
    .req1_a_i(req1_a), .req1_b_i(req1_b), .req1_rmode_i(req1_rm),
    .dp_a_o(dp_a), .dp_b_o(dp_b), .dp_rmode_o(dp_rmode),
    .dp_result_i(dp_result),
    .res_valid_o(res_valid), .res_ready_i(res_ready),
    .res_data_o(res_data), .res_id_o(res_id)
  );

  // Reference add for positive normal operands; rm: 0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM.
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] rm);
    logic [31:0] x, y;
    logic [63:0] mx, my, sum, lost;
    logic [8:0]  e;
    logic [24:0] m;
    logic        g, rest, lsb, inc, sticky;
    int          d;
    if (a[30:23] >= b[30:23]) begin x = a; y = b; end
    else begin x = b; y = a; end
    d  = int'(x[30:23]) - int'(y[30:23]);
    mx = {40'd0, 1'b1, x[22:0]} << 30;
    my = {40'd0, 1'b1, y[22:0]} << 30;
    sticky = 1'b0;
    if (d >= 54) begin
      sticky = 1'b1;
      my = '0;
    end else if (d > 0) begin
      lost   = my & ((64'd1 << d) - 64'd1);
      sticky = |lost;
      my     = my >> d;
    end
    sum = mx + my;
    e   = {1'b0, x[30:23]};
    if (sum[54]) begin
      sticky = sticky | sum[0];
      sum    = sum >> 1;
      e      = e + 9'd1;
    end
    lsb  = sum[30];
    g    = sum[29];
    rest = (|sum[28:0]) | sticky;
    case (rm)
      3'd0:    inc = g & (rest | lsb);
      3'd3:    inc = g | rest;
      3'd4:    inc = g;
      default: inc = 1'b0;
    endcase
    m = {1'b0, sum[53:30]} + 25'(inc);
    if (m[24]) begin
      m = m >> 1;
      e = e + 9'd1;
    end
    return {1'b0, e[7:0], m[22:0]};
  endfunction

  // External datapath: one adder register stage, rounder combinational on its output.
  logic [31:0] st_a = '0;
  logic [31:0] st_b = '0;
  always @(posedge clk) begin
    st_a <= dp_a;
    st_b <= dp_b;
  end
  always_comb dp_result = fp_add(st_a, st_b, dp_rmode);

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Handshakes are stable at the falling edge, so the scoreboard works there.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (res_valid && res_ready) begin
        checks++;
        assert (sb.size() != 0) else begin
          errors++;
          $error("FAIL spurious_result: observed %h expected none", {res_id, res_data});
        end
        if (sb.size() != 0) begin
          logic [32:0] exp;
          exp = sb.pop_front();
          checks++;
          assert ({res_id, res_data} === exp) else begin
            errors++;
            $error("FAIL result_order: observed %h expected %h", {res_id, res_data}, exp);
          end
        end
        got.push_back({res_id, res_data});
      end
      if (req0_valid && req0_ready) sb.push_back({1'b0, fp_add(req0_a, req0_b, req0_rm)});
      if (req1_valid && req1_ready) sb.push_back({1'b1, fp_add(req1_a, req1_b, req1_rm)});
      checks++;
      assert (sb.size() <= DEPTH) else begin
        errors++;
        $error("FAIL credit_overflow: observed %0d expected <= %0d", sb.size(), DEPTH);
      end
    end
  end

  task automatic next_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || res_valid) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 33'(n < 60), 33'd1);
    next_drive();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    sb.delete();
    got.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    next_drive();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    req0_valid = 0; req1_valid = 0; res_ready = 1'b1;
    req0_a = '0; req0_b = '0; req0_rm = '0;
    req1_a = '0; req1_b = '0; req1_rm = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_res_valid", 33'(res_valid), 33'd0);
    chk("rst_res_data",  33'(res_data),  33'd0);
    chk("rst_res_id",    33'(res_id),    33'd0);
    chk("rst_dp_a",      33'(dp_a),      33'd0);
    chk("rst_dp_b",      33'(dp_b),      33'd0);
    chk("rst_dp_rmode",  33'(dp_rmode),  33'd0);
    #2 rst_n = 1'b1;
    next_drive();

    // Single operation and latency.
    req0_valid = 1; req0_a = 32'h3F800000; req0_b = 32'h40000000; req0_rm = 3'd0;
    @(negedge clk);
    chk("t1_ready", 33'({req1_ready, req0_ready}), 33'b01);
    next_drive();
    req0_valid = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("t1_valid_timing", 33'(res_valid), 33'(k == 3));
      if (k == 3) chk("t1_result", {res_id, res_data}, {1'b0, 32'h40400000});
    end
    next_drive();

    // Fair arbitration.
    do_reset();
    req0_valid = 1; req0_a = 32'h3F800000; req0_b = 32'h3F800000; req0_rm = 3'd0;
    req1_valid = 1; req1_a = 32'h40000000; req1_b = 32'h40000000; req1_rm = 3'd0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t2_grant", 33'({req1_ready, req0_ready}), (i % 2 == 1) ? 33'b10 : 33'b01);
      next_drive();
    end
    req0_valid = 0; req1_valid = 0;
    drain();
    chk("t2_count", 33'(got.size()), 33'd6);
    for (int i = 0; i < 6 && i < got.size(); i++)
      chk("t2_result", got[i], (i % 2 == 1) ? {1'b1, 32'h40800000} : {1'b0, 32'h40000000});

    // Backpressure.
    res_ready = 0;
    req1_valid = 1; req1_a = 32'h40000000; req1_b = 32'h3F800000; req1_rm = 3'd0;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (req1_ready) n++;
      next_drive();
    end
    chk("t3_accepted", 33'(n), 33'(DEPTH));
    res_ready = 1;
    @(negedge clk);
    chk("t3_no_credit_on_pop", 33'(req1_ready), 33'd0);
    next_drive();
    res_ready = 0;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (req1_ready) n++;
      next_drive();
    end
    chk("t3_one_reissue", 33'(n), 33'd1);
    req1_valid = 0; res_ready = 1;
    drain();

    // Full with concurrent completion and pop.
    got.delete();
    res_ready = 0;
    req0_valid = 1; req0_a = 32'h3F800000; req0_rm = 3'd0;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      req0_b    = 32'h3F800000 | (32'(i) << 19);
      res_ready = (i >= 4);
      @(negedge clk);
      if (req0_ready) n++;
      if (i == 4) chk("t4_full_ready", 33'(req0_ready), 33'd0);
      next_drive();
    end
    req0_valid = 0; res_ready = 1;
    drain();
    chk("t4_all_returned", 33'(got.size()), 33'(n));

    // Rmode alignment, back-to-back.
    got.delete();
    req0_a = 32'h3F800001; req0_b = 32'h33800000;
    for (int i = 0; i < 3; i++) begin
      req0_valid = 1;
      req0_rm = (i == 0) ? 3'd0 : (i == 1) ? 3'd3 : 3'd1;
      @(negedge clk);
      chk("t5_ready", 33'(req0_ready), 33'd1);
      next_drive();
    end
    req0_valid = 0;
    drain();
    chk("t5_count", 33'(got.size()), 33'd3);
    if (got.size() == 3) begin
      chk("t5_rne", got[0], {1'b0, 32'h3F800002});
      chk("t5_rup", got[1], {1'b0, 32'h3F800002});
      chk("t5_rtz", got[2], {1'b0, 32'h3F800001});
    end

    // Reset with three operations outstanding; port 0 grants leave prio at 1.
    res_ready = 0;
    req0_a = 32'h3F800000; req0_b = 32'h3F800000; req0_rm = 3'd0;
    for (int i = 0; i < 3; i++) begin
      req0_valid = 1;
      next_drive();
    end
    req0_valid = 0;
    #1 rst_n = 1'b0;
    #1;
    chk("t6_res_valid", 33'(res_valid), 33'd0);
    chk("t6_res_data",  33'(res_data),  33'd0);
    chk("t6_res_id",    33'(res_id),    33'd0);
    chk("t6_dp_a",      33'(dp_a),      33'd0);
    chk("t6_dp_b",      33'(dp_b),      33'd0);
    chk("t6_dp_rmode",  33'(dp_rmode),  33'd0);
    sb.delete();
    got.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    next_drive();
    res_ready = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t6_no_stale", 33'(res_valid), 33'd0);
    end
    next_drive();
    req0_valid = 1; req0_a = 32'h40400000; req0_b = 32'h3F800000; req0_rm = 3'd0;
    req1_valid = 1; req1_a = 32'h40000000; req1_b = 32'h40000000; req1_rm = 3'd0;
    @(negedge clk);
    chk("t6_grant", 33'({req1_ready, req0_ready}), 33'b01);
    next_drive();
    req0_valid = 0; req1_valid = 0;
    repeat (3) @(negedge clk);
    chk("t6_result", {res_id, res_data}, {1'b0, 32'h40800000});
    chk("t6_valid", 33'(res_valid), 33'd1);
    next_drive();
    drain();
    chk("final_scoreboard_empty", 33'(sb.size()), 33'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
